// File: rtl/float_adder_arbiter.sv
// Round-robin arbiter sharing one float_adder among NUM_REQ requesters.
// One operation in flight: IDLE -> ISSUE -> WAIT_Z -> RETURN, with a WAIT_Z timeout.
module float_adder_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 255,
    parameter int ID_W        = 2
) (
    input  logic                    i_CLK,
    input  logic                    i_RSTN,
    input  logic [32*NUM_REQ-1:0]   i_REQ_A,
    input  logic [32*NUM_REQ-1:0]   i_REQ_B,
    input  logic [NUM_REQ-1:0]      i_REQ_STB,
    output logic [NUM_REQ-1:0]      o_REQ_ACK,
    output logic [31:0]             o_RES_Z,
    output logic [NUM_REQ-1:0]      o_RES_STB,
    input  logic [NUM_REQ-1:0]      i_RES_ACK,
    output logic [31:0]             o_ADD_A,
    output logic [31:0]             o_ADD_B,
    output logic                    o_ADD_AB_STB,
    input  logic                    i_ADD_AB_ACK,
    input  logic [31:0]             i_ADD_Z,
    input  logic                    i_ADD_Z_STB,
    output logic                    o_ADD_Z_ACK,
    output logic [ID_W-1:0]         o_GRANT_ID,
    output logic                    o_BUSY,
    output logic                    o_TIMEOUT
);

    localparam int unsigned    NR       = NUM_REQ;
    localparam int unsigned    IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [31:0]    QNAN     = 32'h7FC0_0000;
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_Z, S_RETURN} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [31:0]       a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic              timeout_q, timeout_d;
    logic              busy_q;

    logic              found;
    logic [ID_W-1:0]   win;
    int unsigned       idx;
    logic [NUM_REQ-1:0] win_oh, grant_oh, req_ack;
    logic [31:0]       a_sel, b_sel;
    logic              res_ack_sel;

    // Rotating search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 1; i <= NR; i++) begin
            idx = 32'(last_q) + i;
            if (idx >= NR) idx = idx - NR;
            if (!found && i_REQ_STB[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        win_oh      = '0;
        grant_oh    = '0;
        a_sel       = '0;
        b_sel       = '0;
        res_ack_sel = 1'b0;
        for (int unsigned k = 0; k < NR; k++) begin
            if (win == ID_W'(k)) begin
                win_oh[k] = 1'b1;
                a_sel     = i_REQ_A[32*k +: 32];
                b_sel     = i_REQ_B[32*k +: 32];
            end
            if (grant_q == ID_W'(k)) begin
                grant_oh[k] = 1'b1;
                res_ack_sel = i_RES_ACK[k];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        timeout_d    = timeout_q;
        req_ack      = '0;
        o_ADD_AB_STB = 1'b0;
        o_ADD_Z_ACK  = 1'b0;
        o_RES_STB    = '0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    req_ack = win_oh;
                    a_d     = a_sel;
                    b_d     = b_sel;
                    grant_d = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                o_ADD_AB_STB = 1'b1;
                if (i_ADD_AB_ACK) begin
                    cnt_d   = '0;
                    phase_d = 1'b0;
                    state_d = S_WAIT_Z;
                end
            end
            S_WAIT_Z: begin
                o_ADD_Z_ACK = 1'b1;
                if (i_ADD_Z_STB) begin
                    res_d   = i_ADD_Z;
                    state_d = S_RETURN;
                end else if (cnt_q == TO_MAX) begin
                    timeout_d = 1'b1;
                    res_d     = QNAN;
                    state_d   = S_RETURN;
                end else begin
                    // phase halves the count rate: one increment per two WAIT_Z cycles
                    phase_d = ~phase_q;
                    if (phase_q) cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RETURN: begin
                o_RES_STB = grant_oh;
                if (res_ack_sel) begin
                    last_d  = grant_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RSTN) begin
        if (!i_RSTN) begin
            state_q   <= S_IDLE;
            last_q    <= LAST_RST;
            grant_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            cnt_q     <= cnt_d;
            phase_q   <= phase_d;
            timeout_q <= timeout_d;
            busy_q    <= (state_d != S_IDLE);
        end
    end

    // Ack is combinational from the strobes, so reset must mask it directly.
    assign o_REQ_ACK  = req_ack & {NUM_REQ{i_RSTN}};
    assign o_RES_Z    = res_q;
    assign o_ADD_A    = a_q;
    assign o_ADD_B    = b_q;
    assign o_GRANT_ID = grant_q;
    assign o_BUSY     = busy_q;
    assign o_TIMEOUT  = timeout_q;

endmodule

// File: tb/tb_float_adder_arbiter.sv
// Randomized bench for float_adder_arbiter with a float_adder stub and a
// transaction-level round-robin reference model.
module tb_float_adder_arbiter;

    localparam int unsigned NR   = 3;
    localparam int          TO   = 8;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [95:0] req_a = '0, req_b = '0;
    logic [2:0]  req_stb = '0, res_ack = '0;
    logic [2:0]  req_ack, res_stb;
    logic [31:0] res_z, add_a, add_b, add_z;
    logic        add_ab_stb, add_ab_ack, add_z_stb, add_z_ack, busy, timeout;
    logic [1:0]  grant_id;

    float_adder_arbiter #(.NUM_REQ(3), .TIMEOUT_CYC(TO), .ID_W(2)) dut (
        .i_CLK(clk), .i_RSTN(rstn),
        .i_REQ_A(req_a), .i_REQ_B(req_b), .i_REQ_STB(req_stb), .o_REQ_ACK(req_ack),
        .o_RES_Z(res_z), .o_RES_STB(res_stb), .i_RES_ACK(res_ack),
        .o_ADD_A(add_a), .o_ADD_B(add_b), .o_ADD_AB_STB(add_ab_stb), .i_ADD_AB_ACK(add_ab_ack),
        .i_ADD_Z(add_z), .i_ADD_Z_STB(add_z_stb), .o_ADD_Z_ACK(add_z_ack),
        .o_GRANT_ID(grant_id), .o_BUSY(busy), .o_TIMEOUT(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Exact single-precision encodings of small non-negative integers.
    function automatic logic [31:0] i2f(input int unsigned n);
        int unsigned p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 24; i++) if (((n >> i) & 1) != 0) p = i;
        m = (n << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    function automatic int unsigned f2i(input logic [31:0] f);
        int e;
        if (f[30:0] == 0) return 0;
        e = int'(f[30:23]) - 127;
        return (32'h0080_0000 | {9'b0, f[22:0]}) >> (23 - e);
    endfunction

    function automatic logic [31:0] fsum(input logic [31:0] a, input logic [31:0] b);
        return i2f(f2i(a) + f2i(b));
    endfunction

    function automatic int unsigned rr_pick(input logic [2:0] s, input int unsigned last);
        for (int unsigned i = 1; i <= NR; i++) begin
            int unsigned k = (last + i) % NR;
            if (s[k]) return k;
        end
        return 0;
    endfunction

    // Adder stub configuration
    int stub_ab_hold = 0, stub_lat_max = 2;
    bit stub_noz = 0;

    initial begin
        int st, hcnt, lcnt, lat;
        logic [31:0] sa, sb;
        add_ab_ack = 0; add_z_stb = 0; add_z = '0;
        st = 0; hcnt = 0; lcnt = 0; lat = 0; sa = '0; sb = '0;
        forever begin
            @(negedge clk);
            add_ab_ack = 0;
            if (!rstn) begin
                st = 0; hcnt = 0; add_z_stb = 0;
            end else begin
                if (add_ab_stb && st != 0) begin
                    st = 0; hcnt = 0; add_z_stb = 0;
                end
                case (st)
                    0: if (add_ab_stb) begin
                        if (hcnt < stub_ab_hold) hcnt++;
                        else begin
                            add_ab_ack = 1; sa = add_a; sb = add_b;
                            hcnt = 0; lcnt = 0; lat = $urandom_range(0, stub_lat_max); st = 1;
                        end
                    end
                    1: if (!stub_noz) begin
                        if (lcnt >= lat) begin
                            add_z = fsum(sa, sb); add_z_stb = 1; st = 2;
                        end else lcnt++;
                    end
                    default: begin add_z_stb = 0; st = 0; end
                endcase
            end
        end
    end

    // Reference model state
    int unsigned last_m, infl, gw;
    bit idle_m, grant_pend, ret_pend, to_mode, to_m, rand_gen, rand_hold;
    bit [2:0] outst, inj;
    logic [31:0] ma[3], mb[3], mz[3], ia[3], ib[3];
    logic [31:0] last_z;
    int res_wait, res_hold_cur, res_hold_fix, res_hold_max, rand_pct, wz_cnt, issue_cnt;
    int gq[$];

    task automatic model_init();
        last_m = NR - 1; idle_m = 1; infl = 0; grant_pend = 0; ret_pend = 0;
        outst = '0; inj = '0; to_m = 0; res_wait = 0; wz_cnt = 0; issue_cnt = 0;
    endtask

    task automatic inject(input int k, input logic [31:0] a, input logic [31:0] b);
        inj[k] = 1; ia[k] = a; ib[k] = b;
    endtask

    task automatic step();
        logic [2:0] exp_ack, oh;
        int unsigned w;
        @(negedge clk);
        if (ret_pend) begin
            idle_m = 1; last_m = infl; outst[infl] = 0; ret_pend = 0; res_wait = 0;
        end
        if (grant_pend) begin
            idle_m = 0; infl = gw; req_stb[gw] = 0; grant_pend = 0; wz_cnt = 0;
        end
        for (int k = 0; k < 3; k++) begin
            if (!outst[k] && rand_gen && !inj[k] && $urandom_range(0, 99) < rand_pct)
                inject(k, i2f($urandom_range(0, 100000)), i2f($urandom_range(0, 100000)));
            if (!outst[k] && inj[k]) begin
                req_a[32*k +: 32] = ia[k]; req_b[32*k +: 32] = ib[k];
                ma[k] = ia[k]; mb[k] = ib[k]; mz[k] = fsum(ia[k], ib[k]);
                req_stb[k] = 1; outst[k] = 1; inj[k] = 0;
            end
        end
        res_ack = 3'($urandom);
        res_ack[infl] = 1'b0;
        #1;
        exp_ack = '0;
        w = rr_pick(req_stb, last_m);
        if (idle_m && req_stb != 0) exp_ack[w] = 1'b1;
        chk("req_ack", 32'(req_ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(!idle_m));
        if (exp_ack != 0) begin
            gw = w; grant_pend = 1; gq.push_back(int'(w));
            if (rand_hold) stub_ab_hold = $urandom_range(0, 3);
        end
        if (add_ab_stb) begin
            issue_cnt++;
            chk("add_a", add_a, ma[infl]);
            chk("add_b", add_b, mb[infl]);
        end else if (issue_cnt != 0) begin
            chk("issue_len", 32'(issue_cnt), 32'(stub_ab_hold + 1));
            issue_cnt = 0;
        end
        if (add_z_ack) wz_cnt++;
        if (idle_m) chk("res_stb_idle", 32'(res_stb), 32'h0);
        else if (res_stb != 0) begin
            if (res_wait == 0) begin
                if (to_mode) begin
                    to_m = 1;
                    chk("to_window", 32'(wz_cnt >= TO && wz_cnt <= 2*TO + 2), 32'h1);
                end
                res_hold_cur = (res_hold_fix >= 0) ? res_hold_fix : $urandom_range(0, res_hold_max);
            end
            oh = '0; oh[infl] = 1'b1;
            chk("res_stb", 32'(res_stb), 32'(oh));
            chk("res_z", res_z, to_mode ? QNAN : mz[infl]);
            chk("grant_id", 32'(grant_id), infl);
            last_z = res_z;
            res_wait++;
            if (res_wait > res_hold_cur) begin
                res_ack[infl] = 1'b1; ret_pend = 1;
            end
        end
        chk("timeout_flag", 32'(timeout), 32'(to_m));
    endtask

    task automatic drain(input int maxc);
        int c = 0;
        while ((outst != 0 || inj != 0 || !idle_m || ret_pend || grant_pend) && c < maxc) begin
            step(); c++;
        end
        if (c >= maxc) chk("drain_bound", 32'(c), 32'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_req_ack"}, 32'(req_ack), 32'h0);
        chk({tag, "_res_stb"}, 32'(res_stb), 32'h0);
        chk({tag, "_res_z"}, res_z, 32'h0);
        chk({tag, "_ab_stb"}, 32'(add_ab_stb), 32'h0);
        chk({tag, "_z_ack"}, 32'(add_z_ack), 32'h0);
        chk({tag, "_add_a"}, add_a, 32'h0);
        chk({tag, "_add_b"}, add_b, 32'h0);
        chk({tag, "_gid"}, 32'(grant_id), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_timeout"}, 32'(timeout), 32'h0);
    endtask

    task automatic do_reset();
        rstn = 0; req_stb = '0; res_ack = '0;
        model_init();
        repeat (3) @(negedge clk);
        rstn = 1;
    endtask

    initial begin
        int c;
        model_init();
        to_mode = 0; rand_gen = 0; rand_hold = 0; rand_pct = 0;
        res_hold_fix = 0; res_hold_max = 0; last_z = '0;

        // Reset state, with strobes high to confirm the combinational ack is masked
        rstn = 0; req_stb = '1;
        repeat (2) @(negedge clk);
        #1;
        check_zero_outputs("rst");
        do_reset();

        // Single request: 1.0 + 2.0
        inject(0, 32'h3F80_0000, 32'h4000_0000);
        drain(100);
        chk("single_z", last_z, 32'h4040_0000);
        chk("single_gid", 32'(grant_id), 32'h0);

        // Simultaneous requests from reset, then 0 and 2 again
        do_reset();
        gq.delete();
        inject(0, i2f(1), i2f(2));
        inject(1, i2f(5), i2f(7));
        inject(2, i2f(100), i2f(23));
        drain(200);
        inject(0, i2f(40), i2f(2));
        inject(2, i2f(9), i2f(9));
        drain(200);
        chk("order_n", gq.size(), 5);
        chk("order0", gq[0], 0);
        chk("order1", gq[1], 1);
        chk("order2", gq[2], 2);
        chk("order3", gq[3], 0);
        chk("order4", gq[4], 2);

        // Result back-pressure on requester 1 while requester 0 waits
        gq.delete();
        res_hold_fix = 10;
        inject(1, i2f(300), i2f(12));
        step(); step();
        inject(0, i2f(77), i2f(1));
        drain(300);
        res_hold_fix = 0;
        chk("bp_first", gq[0], 1);
        chk("bp_second", gq[1], 0);

        // Slow adder operand acceptance
        stub_ab_hold = 5;
        inject(2, i2f(1234), i2f(4321));
        drain(200);
        stub_ab_hold = 0;

        // Timeout: adder never returns a result
        to_mode = 1; stub_noz = 1;
        inject(1, i2f(8), i2f(8));
        drain(300);
        to_mode = 0; stub_noz = 0;
        inject(0, i2f(10), i2f(20));
        drain(200);
        chk("after_to_z", last_z, i2f(30));

        // Asynchronous reset in WAIT_Z with another request pending
        stub_noz = 1;
        inject(0, i2f(3), i2f(4));
        c = 0;
        while (!add_z_ack && c < 50) begin step(); c++; end
        if (c >= 50) chk("wz_reach", 32'(c), 32'h0);
        inject(1, i2f(6), i2f(6));
        step();
        #2;
        rstn = 0;
        #1;
        check_zero_outputs("async_rst");
        model_init();
        stub_noz = 0; req_stb = '0; res_ack = '0;
        repeat (2) @(negedge clk);
        rstn = 1;
        gq.delete();
        inject(0, i2f(11), i2f(1));
        inject(1, i2f(12), i2f(2));
        inject(2, i2f(13), i2f(3));
        drain(200);
        chk("rst_order0", gq[0], 0);
        chk("rst_order1", gq[1], 1);
        chk("rst_order2", gq[2], 2);

        // Randomized traffic
        rand_gen = 1; rand_pct = 30; rand_hold = 1;
        res_hold_fix = -1; res_hold_max = 3; stub_lat_max = 4;
        repeat (1500) step();
        rand_gen = 0;
        drain(300);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
